// File: rtl/cmd_proc_pkg.sv
// Shared definitions for the parametrised command processor: opcode classes,
// FSM states and instruction field helpers.
package cmd_proc_pkg;

  localparam int unsigned OP_W  = 16;
  localparam int unsigned CLS_W = 8;
  localparam int unsigned FLD_W = 4;

  localparam logic [CLS_W-1:0] OP_ADD   = 8'h0A;
  localparam logic [CLS_W-1:0] OP_SUB   = 8'h05;
  localparam logic [CLS_W-1:0] OP_MOV   = 8'hC0;
  localparam logic [CLS_W-1:0] OP_XCHG  = 8'hEC;
  localparam logic [CLS_W-1:0] OP_PUSH  = 8'h50;
  localparam logic [CLS_W-1:0] OP_POP   = 8'h60;
  localparam logic [CLS_W-1:0] OP_RET   = 8'hE7;
  localparam logic [CLS_W-1:0] OP_HALT  = 8'hFF;
  localparam logic [CLS_W-1:0] OP_LOAD  = 8'h20;
  localparam logic [CLS_W-1:0] OP_STORE = 8'hF0;
  localparam logic [CLS_W-1:0] OP_ADDM  = 8'hAD;
  localparam logic [CLS_W-1:0] OP_SUBM  = 8'h5B;
  localparam logic [CLS_W-1:0] OP_JMP   = 8'hBB;
  localparam logic [CLS_W-1:0] OP_BEQ   = 8'hB0;
  localparam logic [CLS_W-1:0] OP_BGT   = 8'hB1;
  localparam logic [CLS_W-1:0] OP_BLT   = 8'hB2;
  localparam logic [CLS_W-1:0] OP_CALL  = 8'hCA;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_ARG, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
  } state_e;

  function automatic logic [CLS_W-1:0] op_class(input logic [OP_W-1:0] op);
    return op[15:8];
  endfunction

  function automatic logic [FLD_W-1:0] op_rd(input logic [OP_W-1:0] op);
    return op[7:4];
  endfunction

  function automatic logic [FLD_W-1:0] op_rs(input logic [OP_W-1:0] op);
    return op[3:0];
  endfunction

  function automatic logic class_legal(input logic [CLS_W-1:0] c);
    case (c)
      OP_ADD, OP_SUB, OP_MOV, OP_XCHG, OP_PUSH, OP_POP, OP_RET, OP_HALT,
      OP_LOAD, OP_STORE, OP_ADDM, OP_SUBM, OP_JMP, OP_BEQ, OP_BGT, OP_BLT,
      OP_CALL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic class_has_arg(input logic [CLS_W-1:0] c);
    case (c)
      OP_LOAD, OP_STORE, OP_ADDM, OP_SUBM, OP_JMP, OP_BEQ, OP_BGT, OP_BLT,
      OP_CALL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Only fields an instruction actually reads are range-checked.
  function automatic logic uses_rd(input logic [CLS_W-1:0] c);
    case (c)
      OP_ADD, OP_SUB, OP_MOV, OP_XCHG, OP_POP, OP_LOAD, OP_ADDM, OP_SUBM,
      OP_BEQ, OP_BGT, OP_BLT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs(input logic [CLS_W-1:0] c);
    case (c)
      OP_ADD, OP_SUB, OP_MOV, OP_XCHG, OP_PUSH, OP_STORE,
      OP_BEQ, OP_BGT, OP_BLT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cmd_proc_regfile.sv
// General register file: two combinational read ports, one synchronous write
// port, synchronous clear.
module cmd_proc_regfile #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREGS  = 4,
  parameter int unsigned IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  ra_idx,
  output logic [DATA_W-1:0] ra_data_c,
  input  logic [IDX_W-1:0]  rb_idx,
  output logic [DATA_W-1:0] rb_data_c,
  input  logic              we,
  input  logic [IDX_W-1:0]  w_idx,
  input  logic [DATA_W-1:0] w_data
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (we) begin
      regs[w_idx] <= w_data;
    end
  end

  assign ra_data_c = regs[ra_idx];
  assign rb_data_c = regs[rb_idx];

endmodule

// File: rtl/cmd_processor_param.sv
// Parametrised command processor: fetch/decode/execute over a single req/ack
// memory port, with general registers, hardware stack and branch support.
module cmd_processor_param
  import cmd_proc_pkg::*;
#(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       NREGS     = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [ADDR_W-1:0] STACK_TOP = '1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              done,
  output logic              fault,
  output logic [ADDR_W-1:0] fault_pc
);

  localparam int unsigned IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cmd_ptr_q, cmd_ptr_d, stk_ptr_q, stk_ptr_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] arg_q, arg_d, mdata_q, mdata_d, tmp_q, tmp_d;
  logic              mem_req_d, mem_we_d, done_d, fault_d;
  logic [ADDR_W-1:0] mem_addr_d, fault_pc_d;
  logic [DATA_W-1:0] mem_wdata_d;

  logic              rf_we;
  logic [IDX_W-1:0]  rf_widx;
  logic [DATA_W-1:0] rf_wdata, rd_val, rs_val;

  logic [CLS_W-1:0]  cls;
  logic [IDX_W-1:0]  rd_idx, rs_idx;
  logic              rd_bad, rs_bad, taken;
  logic [ADDR_W-1:0] tgt, pc_next1, pc_next2;

  assign cls      = op_class(op_q);
  assign rd_idx   = IDX_W'(op_rd(op_q));
  assign rs_idx   = IDX_W'(op_rs(op_q));
  assign rd_bad   = 32'(op_rd(op_q)) >= NREGS;
  assign rs_bad   = 32'(op_rs(op_q)) >= NREGS;
  assign tgt      = ADDR_W'(arg_q);
  assign pc_next1 = cmd_ptr_q + ADDR_W'(1);
  assign pc_next2 = cmd_ptr_q + ADDR_W'(2);

  always_comb begin
    taken = 1'b0;
    case (cls)
      OP_BEQ:  taken = (rd_val == rs_val);
      OP_BGT:  taken = (rd_val >  rs_val);
      OP_BLT:  taken = (rd_val <  rs_val);
      default: taken = 1'b0;
    endcase
  end

  cmd_proc_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .ra_idx    (rd_idx),
    .ra_data_c (rd_val),
    .rb_idx    (rs_idx),
    .rb_data_c (rs_val),
    .we        (rf_we),
    .w_idx     (rf_widx),
    .w_data    (rf_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cmd_ptr_q <= RESET_PC;
      stk_ptr_q <= STACK_TOP;
      op_q      <= '0;
      arg_q     <= '0;
      mdata_q   <= '0;
      tmp_q     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      fault     <= 1'b0;
      fault_pc  <= '0;
    end else begin
      state_q   <= state_d;
      cmd_ptr_q <= cmd_ptr_d;
      stk_ptr_q <= stk_ptr_d;
      op_q      <= op_d;
      arg_q     <= arg_d;
      mdata_q   <= mdata_d;
      tmp_q     <= tmp_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      done      <= done_d;
      fault     <= fault_d;
      fault_pc  <= fault_pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_ptr_d   = cmd_ptr_q;
    stk_ptr_d   = stk_ptr_q;
    op_d        = op_q;
    arg_d       = arg_q;
    mdata_d     = mdata_q;
    tmp_d       = tmp_q;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    done_d      = done;
    fault_d     = fault;
    fault_pc_d  = fault_pc;
    rf_we       = 1'b0;
    rf_widx     = rd_idx;
    rf_wdata    = rd_val;

    unique case (state_q)
      S_FETCH: begin
        if (!mem_req) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = cmd_ptr_q;
        end else if (mem_ack) begin
          mem_req_d = 1'b0;
          op_d      = mem_rdata[OP_W-1:0];
          state_d   = S_DECODE;
        end
      end

      S_DECODE: begin
        if (!class_legal(cls) || (uses_rd(cls) && rd_bad) || (uses_rs(cls) && rs_bad)) begin
          fault_d    = 1'b1;
          fault_pc_d = cmd_ptr_q;
          state_d    = S_FAULT;
        end else if (cls == OP_HALT) begin
          done_d  = 1'b1;
          state_d = S_HALT;
        end else if (class_has_arg(cls)) begin
          state_d = S_ARG;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_ARG: begin
        if (!mem_req) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = pc_next1;
        end else if (mem_ack) begin
          mem_req_d = 1'b0;
          arg_d     = mem_rdata;
          state_d   = S_EXEC;
        end
      end

      // Register-only ops retire here; XCHG writes rs now and rd in WB.
      S_EXEC: begin
        case (cls)
          OP_ADD, OP_SUB, OP_MOV: begin
            rf_we     = 1'b1;
            rf_wdata  = (cls == OP_ADD) ? rd_val + rs_val :
                        (cls == OP_SUB) ? rd_val - rs_val : rs_val;
            cmd_ptr_d = pc_next1;
            state_d   = S_FETCH;
          end
          OP_XCHG: begin
            rf_we    = 1'b1;
            rf_widx  = rs_idx;
            rf_wdata = rd_val;
            tmp_d    = rs_val;
            state_d  = S_WB;
          end
          OP_PUSH, OP_CALL: begin
            if (stk_ptr_q == '0) begin
              fault_d    = 1'b1;
              fault_pc_d = cmd_ptr_q;
              state_d    = S_FAULT;
            end else begin
              state_d = S_MEM;
            end
          end
          OP_POP, OP_RET: begin
            if (stk_ptr_q == STACK_TOP) begin
              fault_d    = 1'b1;
              fault_pc_d = cmd_ptr_q;
              state_d    = S_FAULT;
            end else begin
              stk_ptr_d = stk_ptr_q + ADDR_W'(1);
              state_d   = S_MEM;
            end
          end
          OP_LOAD, OP_STORE, OP_ADDM, OP_SUBM: state_d = S_MEM;
          OP_JMP: begin
            cmd_ptr_d = tgt;
            state_d   = S_FETCH;
          end
          OP_BEQ, OP_BGT, OP_BLT: begin
            cmd_ptr_d = taken ? tgt : pc_next2;
            state_d   = S_FETCH;
          end
          default: begin
            fault_d    = 1'b1;
            fault_pc_d = cmd_ptr_q;
            state_d    = S_FAULT;
          end
        endcase
      end

      S_MEM: begin
        if (!mem_req) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = tgt;
          case (cls)
            OP_PUSH: begin
              mem_we_d    = 1'b1;
              mem_addr_d  = stk_ptr_q;
              mem_wdata_d = rs_val;
            end
            OP_CALL: begin
              mem_we_d    = 1'b1;
              mem_addr_d  = stk_ptr_q;
              mem_wdata_d = DATA_W'(pc_next2);
            end
            OP_POP, OP_RET: mem_addr_d = stk_ptr_q;
            OP_STORE: begin
              mem_we_d    = 1'b1;
              mem_wdata_d = rs_val;
            end
            default: mem_we_d = 1'b0;
          endcase
        end else if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          mdata_d   = mem_rdata;
          if (cls == OP_PUSH || cls == OP_CALL) stk_ptr_d = stk_ptr_q - ADDR_W'(1);
          state_d = S_WB;
        end
      end

      S_WB: begin
        state_d   = S_FETCH;
        cmd_ptr_d = pc_next2;
        case (cls)
          OP_XCHG: begin
            rf_we     = 1'b1;
            rf_wdata  = tmp_q;
            cmd_ptr_d = pc_next1;
          end
          OP_POP: begin
            rf_we     = 1'b1;
            rf_wdata  = mdata_q;
            cmd_ptr_d = pc_next1;
          end
          OP_PUSH: cmd_ptr_d = pc_next1;
          OP_RET:  cmd_ptr_d = ADDR_W'(mdata_q);
          OP_CALL: cmd_ptr_d = tgt;
          OP_LOAD: begin
            rf_we    = 1'b1;
            rf_wdata = mdata_q;
          end
          OP_ADDM: begin
            rf_we    = 1'b1;
            rf_wdata = rd_val + mdata_q;
          end
          OP_SUBM: begin
            rf_we    = 1'b1;
            rf_wdata = rd_val - mdata_q;
          end
          default: cmd_ptr_d = pc_next2;
        endcase
      end

      S_HALT, S_FAULT: state_d = state_q;
    endcase
  end

endmodule

// File: tb/tb_cmd_processor_param.sv
// Directed program tests for cmd_processor_param against a behavioural memory
// with selectable ack latency; a second small instance covers NREGS=2 and
// stack overflow.
module tb_cmd_processor_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we, mem_ack, done, fault;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, fault_pc;

  logic        b_req, b_we, b_ack, b_done, b_fault;
  logic [7:0]  b_addr, b_fault_pc;
  logic [15:0] b_wdata, b_rdata;

  logic [15:0] mem  [0:65535];
  logic [15:0] mem2 [0:255];

  logic        ld_en = 1'b0, ld_sel = 1'b0;
  logic [15:0] ld_addr = '0, ld_data = '0;
  int          delay_mode = 0;
  int          wait_cnt = 0;
  int          d;
  logic        busy = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cmd_processor_param dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .done(done), .fault(fault), .fault_pc(fault_pc)
  );

  cmd_processor_param #(
    .DATA_W(16), .ADDR_W(8), .NREGS(2), .RESET_PC(8'h10), .STACK_TOP(8'h01)
  ) dut_b (
    .clk(clk), .rst(rst), .mem_req(b_req), .mem_we(b_we), .mem_addr(b_addr),
    .mem_wdata(b_wdata), .mem_ack(b_ack), .mem_rdata(b_rdata),
    .done(b_done), .fault(b_fault), .fault_pc(b_fault_pc)
  );

  // Main memory: mode 0 = ack next cycle, 1 = random 0..7 extra, 2 = 20 extra.
  always @(posedge clk) begin
    mem_ack <= 1'b0;
    if (ld_en && !ld_sel) mem[ld_addr] <= ld_data;
    if (rst) begin
      busy <= 1'b0;
    end else if (mem_req && !mem_ack) begin
      if (!busy) begin
        d = (delay_mode == 1) ? int'($urandom_range(0, 7)) : (delay_mode == 2 ? 20 : 0);
        if (d == 0) begin
          mem_ack <= 1'b1;
          if (mem_we) mem[mem_addr] <= mem_wdata;
          else        mem_rdata <= mem[mem_addr];
        end else begin
          busy     <= 1'b1;
          wait_cnt <= d - 1;
        end
      end else if (wait_cnt == 0) begin
        busy    <= 1'b0;
        mem_ack <= 1'b1;
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else        mem_rdata <= mem[mem_addr];
      end else begin
        wait_cnt <= wait_cnt - 1;
      end
    end
  end

  always @(posedge clk) begin
    b_ack <= 1'b0;
    if (ld_en && ld_sel) mem2[ld_addr[7:0]] <= ld_data;
    if (!rst && b_req && !b_ack) begin
      b_ack <= 1'b1;
      if (b_we) mem2[b_addr] <= b_wdata;
      else      b_rdata <= mem2[b_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic ld(input bit sel, input int a, input logic [15:0] v);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_sel  = sel;
    ld_addr = 16'(a);
    ld_data = v;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic begin_test();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 256; i++) ld(1'b0, i, 16'h0000);
    ld(1'b0, 16'hFFFE, 16'h0000);
    ld(1'b0, 16'hFFFF, 16'h0000);
  endtask

  task automatic run(input int mode);
    int cyc;
    delay_mode = mode;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    while (!(done || fault) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int reqs;

    for (int i = 0; i < 256; i++) ld(1'b1, i, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_done_fault", 32'({done, fault}), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);

    // 1: LOAD/LOAD/ADD/STORE/HALT
    begin_test();
    ld(0, 16'h00, 16'h2000); ld(0, 16'h01, 16'h0040);
    ld(0, 16'h02, 16'h2010); ld(0, 16'h03, 16'h0041);
    ld(0, 16'h04, 16'h0A01);
    ld(0, 16'h05, 16'hF000); ld(0, 16'h06, 16'h0042);
    ld(0, 16'h07, 16'hFF00);
    ld(0, 16'h40, 16'h0005); ld(0, 16'h41, 16'h0003);
    run(1);
    check("t1_done", 32'(done), 32'd1);
    check("t1_fault", 32'(fault), 32'd0);
    check("t1_m42", 32'(mem[16'h42]), 32'h8);

    // 2: wrap on ADD and SUB, then XCHG
    begin_test();
    ld(0, 16'h00, 16'h2000); ld(0, 16'h01, 16'h0040);
    ld(0, 16'h02, 16'h2010); ld(0, 16'h03, 16'h0041);
    ld(0, 16'h04, 16'h0A01);
    ld(0, 16'h05, 16'hF000); ld(0, 16'h06, 16'h0050);
    ld(0, 16'h07, 16'hC013);
    ld(0, 16'h08, 16'h0510);
    ld(0, 16'h09, 16'hF001); ld(0, 16'h0A, 16'h0051);
    ld(0, 16'h0B, 16'hEC01);
    ld(0, 16'h0C, 16'hF000); ld(0, 16'h0D, 16'h0052);
    ld(0, 16'h0E, 16'hF001); ld(0, 16'h0F, 16'h0053);
    ld(0, 16'h10, 16'hFF00);
    ld(0, 16'h40, 16'hFFFF); ld(0, 16'h41, 16'h0002);
    run(1);
    check("t2_done", 32'(done), 32'd1);
    check("t2_add_wrap", 32'(mem[16'h50]), 32'h0001);
    check("t2_sub_wrap", 32'(mem[16'h51]), 32'hFFFF);
    check("t2_xchg_r0", 32'(mem[16'h52]), 32'hFFFF);
    check("t2_xchg_r1", 32'(mem[16'h53]), 32'h0001);

    // 3: BLT loop 0..3, then BEQ taken, BGT not taken
    begin_test();
    ld(0, 16'h00, 16'h2010); ld(0, 16'h01, 16'h0040);
    ld(0, 16'h02, 16'h2020); ld(0, 16'h03, 16'h0041);
    ld(0, 16'h04, 16'h0A02);
    ld(0, 16'h05, 16'h0A32);
    ld(0, 16'h06, 16'hB201); ld(0, 16'h07, 16'h0004);
    ld(0, 16'h08, 16'hF003); ld(0, 16'h09, 16'h0042);
    ld(0, 16'h0A, 16'hF000); ld(0, 16'h0B, 16'h0043);
    ld(0, 16'h0C, 16'hB001); ld(0, 16'h0D, 16'h0020);
    ld(0, 16'h0E, 16'hFF00);
    ld(0, 16'h20, 16'hB110); ld(0, 16'h21, 16'h0030);
    ld(0, 16'h22, 16'hF003); ld(0, 16'h23, 16'h0044);
    ld(0, 16'h24, 16'hFF00);
    ld(0, 16'h30, 16'hFF00);
    ld(0, 16'h40, 16'h0003); ld(0, 16'h41, 16'h0001);
    run(1);
    check("t3_done", 32'(done), 32'd1);
    check("t3_iters", 32'(mem[16'h42]), 32'd3);
    check("t3_r0", 32'(mem[16'h43]), 32'd3);
    check("t3_beq_bgt", 32'(mem[16'h44]), 32'd3);

    // 4: JMP 0x10, CALL 0x20, RET to 0x12, then POP underflows at 0x14
    begin_test();
    ld(0, 16'h00, 16'hBB00); ld(0, 16'h01, 16'h0010);
    ld(0, 16'h10, 16'hCA00); ld(0, 16'h11, 16'h0020);
    ld(0, 16'h12, 16'hF000); ld(0, 16'h13, 16'h0041);
    ld(0, 16'h14, 16'h6000);
    ld(0, 16'h20, 16'h2000); ld(0, 16'h21, 16'h0040);
    ld(0, 16'h22, 16'hE700);
    ld(0, 16'h40, 16'h0055);
    run(1);
    check("t4_ret_addr", 32'(mem[16'hFFFF]), 32'h0012);
    check("t4_sub_body", 32'(mem[16'h41]), 32'h0055);
    check("t4_underflow", 32'(fault), 32'd1);
    check("t4_fault_pc", 32'(fault_pc), 32'h14);
    check("t4_done", 32'(done), 32'd0);

    // 4b: PUSH then POP into another register
    begin_test();
    ld(0, 16'h00, 16'h2000); ld(0, 16'h01, 16'h0040);
    ld(0, 16'h02, 16'h5000);
    ld(0, 16'h03, 16'h6010);
    ld(0, 16'h04, 16'hF001); ld(0, 16'h05, 16'h0041);
    ld(0, 16'h06, 16'hFF00);
    ld(0, 16'h40, 16'h1234);
    run(1);
    check("t4b_done", 32'(done), 32'd1);
    check("t4b_push", 32'(mem[16'hFFFF]), 32'h1234);
    check("t4b_pop", 32'(mem[16'h41]), 32'h1234);

    // 5: illegal opcode at 0x05, no further requests
    begin_test();
    for (int i = 0; i < 5; i++) ld(0, i, 16'hC000);
    ld(0, 16'h05, 16'h7700);
    run(0);
    check("t5_fault", 32'(fault), 32'd1);
    check("t5_fault_pc", 32'(fault_pc), 32'h05);
    check("t5_done", 32'(done), 32'd0);
    reqs = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_req) reqs++;
    end
    check("t5_no_req", 32'(reqs), 32'd0);

    // 5b: rd == NREGS on the default instance
    begin_test();
    ld(0, 16'h00, 16'h0A40);
    run(0);
    check("t5b_fault_pc", 32'({fault, fault_pc}), 32'h10000);

    // 5c: NREGS=2 instance, MOV r3 faults
    begin_test();
    ld(0, 16'h00, 16'hFF00);
    ld(1, 16'h10, 16'hC010);
    ld(1, 16'h11, 16'hC030);
    run(0);
    cyc = 0;
    while (!b_fault && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("t5c_fault", 32'(b_fault), 32'd1);
    check("t5c_fault_pc", 32'(b_fault_pc), 32'h11);
    check("t5c_done", 32'(b_done), 32'd0);

    // 5d: stack overflow on the small instance (STACK_TOP=1)
    begin_test();
    ld(0, 16'h00, 16'hFF00);
    ld(1, 16'h00, 16'hBBBB);
    ld(1, 16'h01, 16'hAAAA);
    ld(1, 16'h10, 16'h5000);
    ld(1, 16'h11, 16'h5000);
    run(0);
    cyc = 0;
    while (!b_fault && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("t5d_fault_pc", 32'({b_fault, b_fault_pc}), 32'h111);
    check("t5d_first_push", 32'(mem2[1]), 32'h0000);
    check("t5d_no_write", 32'(mem2[0]), 32'hBBBB);

    // 6: reset during a slow LOAD data read, then clean rerun
    begin_test();
    ld(0, 16'h00, 16'h2000); ld(0, 16'h01, 16'h0040);
    ld(0, 16'h02, 16'h2010); ld(0, 16'h03, 16'h0041);
    ld(0, 16'h04, 16'h0A01);
    ld(0, 16'h05, 16'hF000); ld(0, 16'h06, 16'h0042);
    ld(0, 16'h07, 16'hFF00);
    ld(0, 16'h40, 16'h0005); ld(0, 16'h41, 16'h0003);
    delay_mode = 2;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    while (!(mem_req && !mem_we && mem_addr == 16'h0040) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("t6_reach_load", 32'(mem_req && mem_addr == 16'h0040), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rst_req_we", 32'({mem_req, mem_we}), 32'd0);
    check("t6_rst_addr_wdata", 32'({mem_addr, mem_wdata}), 32'd0);
    check("t6_rst_flags", 32'({done, fault, fault_pc}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    delay_mode = 1;
    cyc = 0;
    while (!mem_req && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("t6_refetch", 32'({mem_req, mem_we, mem_addr}), 32'h20000);
    cyc = 0;
    while (!(done || fault) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check("t6_rerun", 32'({done, fault, mem[16'h42]}), 32'h20008);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
